hilo_acc_file: RTL and testbench
================================

Name: hilo_acc_file

Overview:
- Parametrised successor of the single HI/LO pair: NUM_ACC HI/LO accumulator pairs, in the style of the MIPS DSP ac0..ac3 accumulators.
- Supports direct write (MTHI/MTLO), 2W-bit accumulate/deaccumulate (MADD/MSUB-style, product supplied by the multiplier upstream) and clear.
- Sits between the EX-stage multiplier and the MEM/WB writeback; the read port feeds MFHI/MFLO and the EX-stage operand mux.

Parameters:
- DATA_W, 32, width of each HI and LO half; an accumulator is 2*DATA_W bits.
- NUM_ACC, 4, number of HI/LO pairs (>=1).
- ACC_AW, $clog2(NUM_ACC) (min 1), accumulator select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept an operation this cycle.
- i_op  in  2  00 MOVE, 01 MADD, 10 MSUB, 11 CLEAR.
- i_acc_sel  in  ACC_AW  target accumulator.
- i_we_hi  in  1  MOVE only: write HI half.
- i_we_lo  in  1  MOVE only: write LO half.
- i_hi  in  DATA_W  MOVE: HI data; MADD/MSUB: upper half of signed operand.
- i_lo  in  DATA_W  MOVE: LO data; MADD/MSUB: lower half of signed operand.
- i_rd_sel  in  ACC_AW  read select.
- o_hi  out  DATA_W  HI of accumulator i_rd_sel (combinational from storage).
- o_lo  out  DATA_W  LO of accumulator i_rd_sel.
- o_ovf  out  NUM_ACC  sticky signed-overflow flag per accumulator.

Behaviour:
- Reset: all accumulators 0, o_ovf 0, pipeline stage empty, o_ready 1. Reset asserted mid-accumulate discards the in-flight operation; no partial write.
- Accept: an operation is accepted when i_valid && o_ready at a rising edge. i_valid with o_ready=0 is ignored; the upstream holds the request.
- MOVE: 1-cycle latency. At the accept edge, HI is written if i_we_hi and LO if i_we_lo, independently. o_ready stays 1. o_ovf is unchanged.
- CLEAR: at the accept edge, the selected accumulator and its o_ovf bit are set to 0. o_ready stays 1.
- MADD/MSUB: 2-cycle operation.
  - State IDLE, accept: capture operand {i_hi,i_lo}, op and sel into the stage register. Go to ACC. o_ready=0 during ACC.
  - State ACC: compute acc[sel] +/- operand in 2*DATA_W signed arithmetic, modulo 2^(2*DATA_W). Write both halves at the next edge and return to IDLE; o_ready=1 again.
  - Overflow: signed overflow (operand signs equal for add, or differ for sub, and result sign differs from acc sign) sets o_ovf[sel]. The flag clears only via CLEAR on that accumulator or via reset.
- Back-to-back: a new operation may be accepted in the cycle after ACC completes. Per-accumulator ordering is therefore guaranteed without hazard logic.
- Read port: reflects stored state only; a write becomes visible on the cycle after its edge (see Optional Feature). Read select out of range (i_rd_sel >= NUM_ACC) returns 0. Writes with i_acc_sel >= NUM_ACC are dropped, but MADD/MSUB still take 2 cycles.
- NUM_ACC=1: select inputs are ignored; behaviour is a superset of the single HI/LO register.

Optional Feature:
- Macro HILO_BYPASS_EN.
- Defined: the read port forwards the write of the current cycle. This covers a MOVE being accepted (per-half, by we bits), a CLEAR being accepted, or the ACC-stage result, when the target equals i_rd_sel. o_hi/o_lo then show the post-write value in the same cycle.
- Undefined: the read port shows stored values only; new data appears one cycle after the write edge.

Test Plan:
- Reset then read all accumulators -> o_hi=o_lo=0, o_ovf=0, o_ready=1; assert rst during ACC of MADD acc1 -> acc1 stays 0, o_ready=1 after release.
- MOVE acc2 with we_hi=1, we_lo=0, i_hi=0xDEADBEEF, i_lo=0x12345678 -> next cycle acc2 = {0xDEADBEEF, 0x00000000}, other accumulators unchanged.
- MOVE acc0 = {0,5}, then MADD acc0 operand {0,7} -> o_ready low for exactly 1 cycle; then acc0 = {0,12}. MSUB {0,20} -> acc0 = {0xFFFFFFFF, 0xFFFFFFF8}, o_ovf[0]=0.
- MOVE acc3 = {0x7FFFFFFF, 0xFFFFFFFF}, MADD {0,1} -> acc3 = {0x80000000, 0}, o_ovf[3]=1; a subsequent MOVE keeps the flag; CLEAR acc3 -> acc3=0, o_ovf[3]=0.
- Hold i_valid with MADD acc1 then MOVE acc1 over consecutive cycles -> MOVE accepted only after o_ready returns; final acc1 equals the MOVE data.
- HILO_BYPASS_EN defined: MOVE acc1 i_lo=0xA5A5A5A5 with i_rd_sel=1 -> o_lo=0xA5A5A5A5 in the same cycle; undefined -> old value that cycle, new value the next.

Source files
------------

// File: rtl/hilo_acc_file.sv
// hilo_acc_file: NUM_ACC HI/LO accumulator pairs with MOVE, MADD/MSUB and CLEAR,
// plus a combinational read port and sticky per-accumulator overflow flags.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   i_valid / o_ready   operation request / block can accept this cycle
//   i_op                00 MOVE, 01 MADD, 10 MSUB, 11 CLEAR
//   i_acc_sel           target accumulator
//   i_we_hi, i_we_lo    MOVE half-write enables
//   i_hi, i_lo          MOVE data, or the signed 2*DATA_W MADD/MSUB operand
//   i_rd_sel            read select; o_hi/o_lo show that accumulator
//   o_ovf               sticky signed-overflow flag per accumulator
//
// Build option: define HILO_BYPASS_EN to forward the current cycle's write
// (MOVE, CLEAR or accumulate result) onto o_hi/o_lo in the same cycle.
module hilo_acc_file #(
    parameter int DATA_W  = 32,
    parameter int NUM_ACC = 4,
    parameter int ACC_AW  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [ACC_AW-1:0]  i_acc_sel,
    input  logic               i_we_hi,
    input  logic               i_we_lo,
    input  logic [DATA_W-1:0]  i_hi,
    input  logic [DATA_W-1:0]  i_lo,
    input  logic [ACC_AW-1:0]  i_rd_sel,
    output logic [DATA_W-1:0]  o_hi,
    output logic [DATA_W-1:0]  o_lo,
    output logic [NUM_ACC-1:0] o_ovf
);

    localparam int AW2 = 2 * DATA_W;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_MADD  = 2'b01;
    localparam logic [1:0] OP_MSUB  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    typedef logic [AW2-1:0] acc_t;

    state_t                   state_q, state_d;
    acc_t   [NUM_ACC-1:0]     acc_q, acc_d;
    logic   [NUM_ACC-1:0]     ovf_q, ovf_d;
    logic                     sub_q, sub_d;
    logic   [ACC_AW-1:0]      sel_q, sel_d;
    acc_t                     opnd_q, opnd_d;

    acc_t                     cur;
    acc_t                     res;
    logic                     opnd_sign;
    logic                     ovf_hit;
    logic                     accept;
    acc_t   [NUM_ACC-1:0]     rd_src;

    // With a single pair every select matches; otherwise an out-of-range
    // select matches nothing, so writes drop and reads return zero.
    function automatic logic hit(input logic [ACC_AW-1:0] s, input int a);
        return (NUM_ACC == 1) || (s == a[ACC_AW-1:0]);
    endfunction

    assign o_ready = (state_q == IDLE);
    assign accept  = i_valid && o_ready;
    assign o_ovf   = ovf_q;

    always_comb begin
        cur = '0;
        for (int a = 0; a < NUM_ACC; a++) begin
            if (hit(sel_q, a)) begin
                cur = acc_q[a];
            end
        end
        res = sub_q ? (cur - opnd_q) : (cur + opnd_q);
        // Subtraction overflows like adding an operand of opposite sign.
        opnd_sign = opnd_q[AW2-1] ^ sub_q;
        ovf_hit   = (cur[AW2-1] == opnd_sign) && (res[AW2-1] != cur[AW2-1]);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        sub_d   = sub_q;
        sel_d   = sel_q;
        opnd_d  = opnd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (i_op)
                        OP_MOVE: begin
                            for (int a = 0; a < NUM_ACC; a++) begin
                                if (hit(i_acc_sel, a)) begin
                                    if (i_we_hi) acc_d[a][AW2-1:DATA_W] = i_hi;
                                    if (i_we_lo) acc_d[a][DATA_W-1:0]   = i_lo;
                                end
                            end
                        end
                        OP_MADD, OP_MSUB: begin
                            sub_d   = (i_op == OP_MSUB);
                            sel_d   = i_acc_sel;
                            opnd_d  = {i_hi, i_lo};
                            state_d = ACC;
                        end
                        OP_CLEAR: begin
                            for (int a = 0; a < NUM_ACC; a++) begin
                                if (hit(i_acc_sel, a)) begin
                                    acc_d[a] = '0;
                                    ovf_d[a] = 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ACC: begin
                for (int a = 0; a < NUM_ACC; a++) begin
                    if (hit(sel_q, a)) begin
                        acc_d[a] = res;
                        if (ovf_hit) ovf_d[a] = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= '0;
            sub_q   <= 1'b0;
            sel_q   <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            sub_q   <= sub_d;
            sel_q   <= sel_d;
            opnd_q  <= opnd_d;
        end
    end

`ifdef HILO_BYPASS_EN
    assign rd_src = acc_d;
`else
    assign rd_src = acc_q;
`endif

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        for (int a = 0; a < NUM_ACC; a++) begin
            if (hit(i_rd_sel, a)) begin
                o_hi = rd_src[a][AW2-1:DATA_W];
                o_lo = rd_src[a][DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hilo_acc_file.sv
// Scoreboard bench for hilo_acc_file: a 64-bit-per-accumulator reference model
// predicts each cycle's read port, flags and ready; a monitor compares at negedge.
module tb_hilo_acc_file;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [1:0]  i_acc_sel;
    logic        i_we_hi;
    logic        i_we_lo;
    logic [31:0] i_hi;
    logic [31:0] i_lo;
    logic [1:0]  i_rd_sel;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [3:0]  o_ovf;

    hilo_acc_file dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_acc_sel (i_acc_sel),
        .i_we_hi   (i_we_hi),
        .i_we_lo   (i_we_lo),
        .i_hi      (i_hi),
        .i_lo      (i_lo),
        .i_rd_sel  (i_rd_sel),
        .o_hi      (o_hi),
        .o_lo      (o_lo),
        .o_ovf     (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  ovf;
        logic        rdy;
        logic [31:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    // Reference model: plain 64-bit accumulators and one pending operation.
    logic [63:0] m_acc[4];
    logic [3:0]  m_ovf;
    logic        m_pend;
    logic        m_sub;
    logic [1:0]  m_sel;
    logic [63:0] m_opnd;

    localparam logic signed [65:0] MAXV = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINV = -66'sh0_8000_0000_0000_0000;

    task automatic model_reset();
        for (int a = 0; a < 4; a++) m_acc[a] = '0;
        m_ovf  = '0;
        m_pend = 1'b0;
        m_sub  = 1'b0;
        m_sel  = '0;
        m_opnd = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want, input logic [31:0] id);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("o_hi", o_hi, e.hi, e.id);
            chk("o_lo", o_lo, e.lo, e.id);
            chk("o_ovf", {28'd0, o_ovf}, {28'd0, e.ovf}, e.id);
            chk("o_ready", {31'd0, o_ready}, {31'd0, e.rdy}, e.id);
        end
    end

    // Called right after a rising edge: drive inputs, predict, wait an edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [1:0] sel,
                        input logic wh, input logic wl, input logic [31:0] h,
                        input logic [31:0] l, input logic [1:0] rd);
        logic [63:0] n_acc[4];
        logic [3:0]  n_ovf;
        logic        n_pend;
        logic signed [65:0] ea, eo, ex;
        logic [63:0] show;
        exp_t e;
        #1;
        i_valid = v; i_op = op; i_acc_sel = sel;
        i_we_hi = wh; i_we_lo = wl; i_hi = h; i_lo = l; i_rd_sel = rd;
        n_acc  = m_acc;
        n_ovf  = m_ovf;
        n_pend = m_pend;
        if (m_pend) begin
            ea = {{2{m_acc[m_sel][63]}}, m_acc[m_sel]};
            eo = {{2{m_opnd[63]}}, m_opnd};
            ex = m_sub ? (ea - eo) : (ea + eo);
            n_acc[m_sel] = ex[63:0];
            if (ex > MAXV || ex < MINV) n_ovf[m_sel] = 1'b1;
            n_pend = 1'b0;
        end else if (v) begin
            case (op)
                2'b00: begin
                    if (wh) n_acc[sel][63:32] = h;
                    if (wl) n_acc[sel][31:0]  = l;
                end
                2'b11: begin
                    n_acc[sel] = '0;
                    n_ovf[sel] = 1'b0;
                end
                default: begin
                    n_pend = 1'b1;
                    m_sub  = (op == 2'b10);
                    m_sel  = sel;
                    m_opnd = {h, l};
                end
            endcase
        end
`ifdef HILO_BYPASS_EN
        show = n_acc[rd];
`else
        show = m_acc[rd];
`endif
        e.hi  = show[63:32];
        e.lo  = show[31:0];
        e.ovf = m_ovf;
        e.rdy = !m_pend;
        e.id  = step_id;
        exp_q.push_back(e);
        step_id++;
        @(posedge clk);
        m_acc  = n_acc;
        m_ovf  = n_ovf;
        m_pend = n_pend;
    endtask

    task automatic idle(input logic [1:0] rd);
        step(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_v, r_wh, r_wl, last_rej;
        logic [1:0]  r_op, r_sel;
        logic [31:0] r_h, r_l;
        int          waits;
        rst = 1'b1;
        i_valid = 0; i_op = 0; i_acc_sel = 0; i_we_hi = 0; i_we_lo = 0;
        i_hi = 0; i_lo = 0; i_rd_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        for (int a = 0; a < 4; a++) idle(2'(a));

        // reset during the accumulate cycle discards it
        step(1, 2'b01, 2'd1, 0, 0, 32'd0, 32'd3, 2'd1);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        idle(2'd1);
        idle(2'd1);

        step(1, 2'b00, 2'd2, 1, 0, 32'hDEADBEEF, 32'h12345678, 2'd2);
        idle(2'd2);
        idle(2'd0);

        step(1, 2'b00, 2'd0, 1, 1, 32'd0, 32'd5, 2'd0);
        step(1, 2'b01, 2'd0, 0, 0, 32'd0, 32'd7, 2'd0);
        idle(2'd0);
        idle(2'd0);
        step(1, 2'b10, 2'd0, 0, 0, 32'd0, 32'd20, 2'd0);
        idle(2'd0);
        idle(2'd0);

        step(1, 2'b00, 2'd3, 1, 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 2'd3);
        step(1, 2'b01, 2'd3, 0, 0, 32'd0, 32'd1, 2'd3);
        idle(2'd3);
        idle(2'd3);
        step(1, 2'b00, 2'd3, 0, 1, 32'd0, 32'h11, 2'd3);
        idle(2'd3);
        step(1, 2'b11, 2'd3, 0, 0, 32'd0, 32'd0, 2'd3);
        idle(2'd3);

        // MOVE held behind MADD is accepted only once ready returns
        step(1, 2'b01, 2'd1, 0, 0, 32'd0, 32'd9, 2'd1);
        step(1, 2'b00, 2'd1, 1, 1, 32'hCAFE0001, 32'hBEEF0002, 2'd1);
        step(1, 2'b00, 2'd1, 1, 1, 32'hCAFE0001, 32'hBEEF0002, 2'd1);
        idle(2'd1);

        step(1, 2'b00, 2'd1, 0, 1, 32'd0, 32'hA5A5A5A5, 2'd1);
        idle(2'd1);

        last_rej = 1'b0;
        r_v = 0; r_op = 0; r_sel = 0; r_wh = 0; r_wl = 0; r_h = 0; r_l = 0;
        for (int n = 0; n < 600; n++) begin
            if (!last_rej) begin
                r_v   = ($urandom_range(0, 3) != 0);
                r_op  = 2'($urandom_range(0, 3));
                if (r_op == 2'b11 && $urandom_range(0, 2) != 0)
                    r_op = 2'b01;
                r_sel = 2'($urandom_range(0, 3));
                r_wh  = 1'($urandom_range(0, 1));
                r_wl  = 1'($urandom_range(0, 1));
                r_h   = pick();
                r_l   = pick();
            end
            last_rej = r_v && m_pend;
            step(r_v, r_op, r_sel, r_wh, r_wl, r_h, r_l,
                 2'($urandom_range(0, 3)));
        end
        idle(2'd0);

        waits = 0;
        while (exp_q.size() > 0 && waits < 5) begin
            @(posedge clk);
            waits++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
